// File: rtl/brushless_comm_if.sv
// Signal bundle between the commutation stage and its surroundings: hall sensors,
// PWM sync, brake/drive commands in; duty word, phase selects and status out.
interface brushless_comm_if;
  logic        hallGrn;
  logic        hallYlw;
  logic        hallBlu;
  logic        PWM_synch;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        clr_fault;
  logic [10:0] duty;
  logic [1:0]  selGrn;
  logic [1:0]  selYlw;
  logic [1:0]  selBlu;
  logic        dir;
  logic [15:0] comm_cnt;
  logic        seq_err;
  logic        hall_fault;

  // Controller / stimulus side.
  modport master (
    output hallGrn, hallYlw, hallBlu, PWM_synch, brake_n, drv_mag, clr_fault,
    input  duty, selGrn, selYlw, selBlu, dir, comm_cnt, seq_err, hall_fault
  );

  // Commutation stage side.
  modport slave (
    input  hallGrn, hallYlw, hallBlu, PWM_synch, brake_n, drv_mag, clr_fault,
    output duty, selGrn, selYlw, selBlu, dir, comm_cnt, seq_err, hall_fault
  );
endinterface

// File: rtl/brushless_comm.sv
// Three-phase commutation stage: synchronizes the hall sensors, samples them on
// PWM_synch, drives registered phase selects and duty, tracks direction/count and
// latches a fault on persistent illegal hall codes.
module brushless_comm #(
  parameter logic [10:0] DUTY_OFFSET = 11'h400,
  parameter logic [10:0] BRAKE_DUTY  = 11'h600,
  parameter int unsigned FAULT_CNT   = 4
) (
  input logic            clk,
  input logic            rst_n,
  brushless_comm_if.slave bus
);

  localparam int unsigned CntW = $clog2(FAULT_CNT + 1);

  // Select codes: 00 off, 01 reverse, 10 forward, 11 regen brake.
  localparam logic [1:0] SelOff   = 2'b00;
  localparam logic [1:0] SelRev   = 2'b01;
  localparam logic [1:0] SelFwd   = 2'b10;
  localparam logic [1:0] SelBrake = 2'b11;

  logic [2:0]      hall_s1;
  logic [2:0]      hall_s2;
  logic [2:0]      rot_state;
  logic            dir_q;
  logic [15:0]     comm_cnt_q;
  logic            seq_err_q;
  logic [CntW-1:0] fault_cnt;
  logic            hall_fault_q;
  logic [10:0]     duty_q;
  logic [1:0]      sel_grn_q;
  logic [1:0]      sel_ylw_q;
  logic [1:0]      sel_blu_q;

  logic            both_legal;
  logic            step_fwd;
  logic            step_rev;
  logic            step_skip;
  logic            new_legal;
  logic [5:0]      table_sel;

  // Only the upper ten magnitude bits feed the duty word.
  logic            unused_mag_lsbs;
  assign unused_mag_lsbs = ^bus.drv_mag[1:0];

  function automatic logic is_legal(input logic [2:0] s);
    return (s != 3'b000) && (s != 3'b111);
  endfunction

  // Forward sequence 101->100->110->010->011->001->101.
  function automatic logic [2:0] fwd_next(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'b101:  n = 3'b100;
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b001;
      3'b001:  n = 3'b101;
      default: n = s;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] fwd_prev(input logic [2:0] s);
    logic [2:0] p;
    case (s)
      3'b101:  p = 3'b001;
      3'b100:  p = 3'b101;
      3'b110:  p = 3'b100;
      3'b010:  p = 3'b110;
      3'b011:  p = 3'b010;
      3'b001:  p = 3'b011;
      default: p = s;
    endcase
    return p;
  endfunction

  // Returns {grn, ylw, blu} select codes for a rotation state.
  function automatic logic [5:0] comm_sel(input logic [2:0] s);
    logic [5:0] r;
    case (s)
      3'b101:  r = {SelFwd, SelRev, SelOff};
      3'b100:  r = {SelFwd, SelOff, SelRev};
      3'b110:  r = {SelOff, SelFwd, SelRev};
      3'b010:  r = {SelRev, SelFwd, SelOff};
      3'b011:  r = {SelRev, SelOff, SelFwd};
      3'b001:  r = {SelOff, SelRev, SelFwd};
      default: r = {SelOff, SelOff, SelOff};
    endcase
    return r;
  endfunction

  // hall_s2 is the value that will be loaded; rot_state is the previous sample.
  assign new_legal  = is_legal(hall_s2);
  assign both_legal = is_legal(rot_state) && new_legal;
  assign step_fwd   = both_legal && (hall_s2 == fwd_next(rot_state));
  assign step_rev   = both_legal && (hall_s2 == fwd_prev(rot_state));
  assign step_skip  = both_legal && (hall_s2 != rot_state) && !step_fwd && !step_rev;
  assign table_sel  = comm_sel(rot_state);

  // Two-flop synchronizer for the asynchronous hall inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1 <= 3'b000;
      hall_s2 <= 3'b000;
    end else begin
      hall_s1 <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
      hall_s2 <= hall_s1;
    end
  end

  // Rotation sampling and transition tracking on each PWM_synch load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_state  <= 3'b000;
      dir_q      <= 1'b1;
      comm_cnt_q <= 16'h0000;
      seq_err_q  <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if (bus.PWM_synch) begin
        rot_state <= hall_s2;
        if (step_fwd) begin
          dir_q      <= 1'b1;
          comm_cnt_q <= comm_cnt_q + 16'd1;
        end else if (step_rev) begin
          dir_q      <= 1'b0;
          comm_cnt_q <= comm_cnt_q + 16'd1;
        end else if (step_skip) begin
          seq_err_q <= 1'b1;
        end
      end
    end
  end

  // Consecutive-illegal counter and fault latch; clr_fault overrides a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt    <= '0;
      hall_fault_q <= 1'b0;
    end else if (bus.clr_fault) begin
      fault_cnt    <= '0;
      hall_fault_q <= 1'b0;
    end else if (bus.PWM_synch) begin
      if (new_legal) begin
        fault_cnt <= '0;
      end else if (fault_cnt != CntW'(FAULT_CNT)) begin
        fault_cnt <= fault_cnt + CntW'(1);
        if (fault_cnt + CntW'(1) == CntW'(FAULT_CNT)) begin
          hall_fault_q <= 1'b1;
        end
      end
    end
  end

  // Registered drive outputs: fault forces off, brake forces regen, else table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= 11'h000;
      sel_grn_q <= SelOff;
      sel_ylw_q <= SelOff;
      sel_blu_q <= SelOff;
    end else begin
      if (!bus.brake_n) begin
        duty_q <= BRAKE_DUTY;
      end else begin
        duty_q <= DUTY_OFFSET + {1'b0, bus.drv_mag[11:2]};
      end
      if (hall_fault_q) begin
        sel_grn_q <= SelOff;
        sel_ylw_q <= SelOff;
        sel_blu_q <= SelOff;
      end else if (!bus.brake_n) begin
        sel_grn_q <= SelBrake;
        sel_ylw_q <= SelBrake;
        sel_blu_q <= SelBrake;
      end else begin
        sel_grn_q <= table_sel[5:4];
        sel_ylw_q <= table_sel[3:2];
        sel_blu_q <= table_sel[1:0];
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.selGrn     = sel_grn_q;
  assign bus.selYlw     = sel_ylw_q;
  assign bus.selBlu     = sel_blu_q;
  assign bus.dir        = dir_q;
  assign bus.comm_cnt   = comm_cnt_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.hall_fault = hall_fault_q;

endmodule

// File: tb/tb_brushless_comm.sv
// Scoreboard bench for brushless_comm: stimulus updates a position-based model and
// queues expected responses; a monitor pops and compares at the due cycle.
module tb_brushless_comm;
  localparam int FaultCnt = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  brushless_comm_if bus ();

  brushless_comm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          kind;   // 0: status, 1: drive outputs
    logic [5:0]  sel;
    logic [10:0] duty;
    logic        dir;
    logic [15:0] cnt;
    logic        serr;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int serr_seen = 0;

  // Reference model: rotor position on the six-step ring.
  logic [2:0] ring [6];
  logic [5:0] ring_sel [6];
  logic [2:0]  m_rot;
  logic        m_dir;
  logic [15:0] m_cnt;
  logic        m_fault;
  int          m_bad;
  int          m_skips = 0;

  function automatic int pos(input logic [2:0] s);
    for (int i = 0; i < 6; i++) if (ring[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [5:0] exp_sel();
    if (m_fault) return 6'b000000;
    if (!bus.brake_n) return 6'b111111;
    if (pos(m_rot) < 0) return 6'b000000;
    return ring_sel[pos(m_rot)];
  endfunction

  function automatic logic [10:0] exp_duty();
    if (!bus.brake_n) return 11'h600;
    return 11'h400 + 11'(bus.drv_mag >> 2);
  endfunction

  task automatic model_reset();
    m_rot = 3'b000; m_dir = 1'b1; m_cnt = 16'h0; m_fault = 1'b0; m_bad = 0;
  endtask

  task automatic model_load(input logic [2:0] nw, output logic serr);
    int po, pn, d;
    po = pos(m_rot);
    pn = pos(nw);
    serr = 1'b0;
    if (nw != m_rot && po >= 0 && pn >= 0) begin
      d = (pn - po + 6) % 6;
      if (d == 1) begin m_dir = 1'b1; m_cnt = m_cnt + 16'd1; end
      else if (d == 5) begin m_dir = 1'b0; m_cnt = m_cnt + 16'd1; end
      else begin serr = 1'b1; m_skips++; end
    end
    if (pn < 0) begin
      if (m_bad < FaultCnt) m_bad++;
      if (m_bad == FaultCnt) m_fault = 1'b1;
    end else begin
      m_bad = 0;
    end
    m_rot = nw;
  endtask

  task automatic push_state(input int due, input logic serr);
    exp_t e;
    e.due = due; e.kind = 1'b0; e.sel = '0; e.duty = '0;
    e.dir = m_dir; e.cnt = m_cnt; e.serr = serr; e.fault = m_fault;
    q.push_back(e);
  endtask

  task automatic push_drive(input int due);
    exp_t e;
    e.due = due; e.kind = 1'b1; e.sel = exp_sel(); e.duty = exp_duty();
    e.dir = 1'b0; e.cnt = '0; e.serr = 1'b0; e.fault = 1'b0;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, want);
    end
  endtask

  // Monitor: compares every queued expectation at its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.seq_err === 1'b1) serr_seen++;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          chk("stale_entry", 32'(cyc), 32'(e.due));
        end else if (e.kind) begin
          chk("sel", {26'h0, bus.selGrn, bus.selYlw, bus.selBlu}, {26'h0, e.sel});
          chk("duty", {21'h0, bus.duty}, {21'h0, e.duty});
        end else begin
          chk("dir", {31'h0, bus.dir}, {31'h0, e.dir});
          chk("comm_cnt", {16'h0, bus.comm_cnt}, {16'h0, e.cnt});
          chk("seq_err", {31'h0, bus.seq_err}, {31'h0, e.serr});
          chk("hall_fault", {31'h0, bus.hall_fault}, {31'h0, e.fault});
        end
      end
    end
  end

  task automatic set_in(input logic [2:0] h, input logic brk, input logic [11:0] mag);
    @(negedge clk);
    {bus.hallGrn, bus.hallYlw, bus.hallBlu} = h;
    bus.brake_n = brk;
    bus.drv_mag = mag;
  endtask

  // One-clk PWM_synch; 'loaded' is the synced hall value the sample will see.
  task automatic pulse(input logic [2:0] loaded);
    logic serr;
    @(negedge clk);
    bus.PWM_synch = 1'b1;
    model_load(loaded, serr);
    push_state(cyc + 1, serr);
    push_drive(cyc + 2);
    @(negedge clk);
    bus.PWM_synch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic step(input logic [2:0] h, input logic brk, input logic [11:0] mag);
    set_in(h, brk, mag);
    repeat (2) @(negedge clk);
    pulse(h);
  endtask

  task automatic change_drive(input logic brk, input logic [11:0] mag);
    @(negedge clk);
    bus.brake_n = brk;
    bus.drv_mag = mag;
    push_drive(cyc + 1);
    repeat (2) @(negedge clk);
  endtask

  // Hall edge with no PWM_synch: outputs must hold.
  task automatic hall_glitch(input logic [2:0] h);
    @(negedge clk);
    {bus.hallGrn, bus.hallYlw, bus.hallBlu} = h;
    repeat (4) @(negedge clk);
    push_drive(cyc + 1);
    push_state(cyc + 1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_fault = 1'b1;
    m_fault = 1'b0;
    m_bad = 0;
    push_state(cyc + 1, 1'b0);
    push_drive(cyc + 2);
    @(negedge clk);
    bus.clr_fault = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_check();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    e.due = cyc + 1; e.kind = 1'b1; e.sel = 6'b0; e.duty = 11'h0;
    e.dir = 1'b0; e.cnt = '0; e.serr = 1'b0; e.fault = 1'b0;
    q.push_back(e);
    push_state(cyc + 1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] nh;
    int p, r;
    ring = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    ring_sel = '{6'b10_01_00, 6'b10_00_01, 6'b00_10_01,
                 6'b01_10_00, 6'b01_00_10, 6'b00_01_10};
    {bus.hallGrn, bus.hallYlw, bus.hallBlu} = 3'b000;
    bus.PWM_synch = 1'b0;
    bus.brake_n = 1'b1;
    bus.drv_mag = 12'h000;
    bus.clr_fault = 1'b0;
    model_reset();
    reset_check();

    // Forward rotation through the whole ring.
    step(3'b101, 1'b1, 12'hFFF);
    step(3'b100, 1'b1, 12'hFFF);
    step(3'b110, 1'b1, 12'hFFF);
    step(3'b010, 1'b1, 12'hFFF);
    step(3'b011, 1'b1, 12'hFFF);
    step(3'b001, 1'b1, 12'hFFF);
    step(3'b101, 1'b1, 12'hFFF);
    // Reverse, skip, then a hall edge with no sample.
    step(3'b001, 1'b1, 12'h123);
    step(3'b110, 1'b1, 12'h123);
    hall_glitch(3'b011);
    // Brake and release.
    step(3'b100, 1'b0, 12'h800);
    change_drive(1'b1, 12'h800);
    // Illegal run shorter than the limit, then a legal code.
    step(3'b111, 1'b1, 12'h800);
    step(3'b111, 1'b1, 12'h800);
    step(3'b111, 1'b1, 12'h800);
    step(3'b101, 1'b1, 12'h800);
    // Four illegal samples latch the fault, overriding brake.
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 12'h800);
    step(3'b101, 1'b0, 12'h800);
    change_drive(1'b1, 12'h400);
    clr_pulse();
    // Sync latency: one clk before the sample is too late, two is enough.
    set_in(3'b001, 1'b1, 12'h400);
    pulse(3'b101);
    set_in(3'b100, 1'b1, 12'h400);
    @(negedge clk);
    pulse(3'b100);
    // Reset mid-operation.
    reset_check();

    // Randomized rotation with brake, magnitude and fault clears mixed in.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      p = pos(m_rot);
      if (r < 35) nh = (p < 0) ? ring[$urandom_range(0, 5)] : ring[(p + 1) % 6];
      else if (r < 60) nh = (p < 0) ? ring[$urandom_range(0, 5)] : ring[(p + 5) % 6];
      else if (r < 72) nh = ring[$urandom_range(0, 5)];
      else if (r < 87) nh = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
      else nh = m_rot;
      step(nh, ($urandom_range(0, 3) != 0), 12'($urandom));
      if ($urandom_range(0, 15) == 0) clr_pulse();
      if ($urandom_range(0, 19) == 0) hall_glitch(3'($urandom));
    end

    for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("seq_err_pulses", 32'(serr_seen), 32'(m_skips));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
